// File: rtl/exception_controller.sv
// Trap controller: qualifies exceptions and synchronised IRQs, selects the highest-priority
// cause, and runs the trap-entry handshake (PEND -> TAKE) with the control unit.
module exception_controller #(
    parameter int unsigned NUM_IRQ       = 8,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned VECTOR_STRIDE = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        exceptionReq,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [15:0]        exceptionMask,
    input  logic               interruptEnable,
    input  logic [31:0]        isrBaseAddress,
    input  logic [31:0]        pc,
    input  logic               trapAck,
    input  logic               eret,
    output logic               exceptionPending,
    output logic [4:0]         cause,
    output logic               trapTaken,
    output logic [31:0]        trapVector,
    output logic [31:0]        epc,
    output logic               inHandler
);

    localparam int unsigned StrideShift = $clog2(VECTOR_STRIDE);

    typedef enum logic [1:0] {StIdle, StPend, StTake} state_e;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [15:0]        exc_latch_q, exc_latch_d, latch_clr;
    logic [4:0]         cause_q, next_cause;
    logic [31:0]        epc_q;
    logic               in_handler_q;
    logic [15:0]        exc_qual;
    logic [NUM_IRQ-1:0] irq_qual;
    logic               any_exc, any_irq, capture;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= irq;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign exc_qual = (exceptionReq | exc_latch_q) & ~exceptionMask;
    assign irq_qual = sync_q[SYNC_STAGES-1] & {NUM_IRQ{interruptEnable & ~in_handler_q}};
    assign any_exc  = |exc_qual;
    assign any_irq  = |irq_qual;
    assign capture  = (state_q == StIdle) && (any_exc || any_irq);

    // Lowest index wins within a group; any exception beats any interrupt.
    always_comb begin
        next_cause = '0;
        for (int i = 15; i >= 0; i--) begin
            if (exc_qual[i]) next_cause = 5'(i);
        end
        if (!any_exc) begin
            for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
                if (irq_qual[i]) next_cause = 5'(16 + i);
            end
        end
    end

    // A request arriving on the bit being cleared in TAKE keeps that bit set.
    always_comb begin
        latch_clr = '0;
        if (state_q == StTake && !cause_q[4]) latch_clr = 16'b1 << cause_q[3:0];
        exc_latch_d = (exc_latch_q & ~latch_clr) | exceptionReq;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_exc || any_irq) state_d = StPend;
            StPend:  if (trapAck) state_d = StTake;
            StTake:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_latch_q  <= '0;
            cause_q      <= '0;
            epc_q        <= '0;
            in_handler_q <= 1'b0;
        end else begin
            exc_latch_q <= exc_latch_d;
            if (capture) begin
                cause_q <= next_cause;
                epc_q   <= pc;
            end
            if (state_q == StTake) begin
                in_handler_q <= 1'b1;
            end else if (eret) begin
                in_handler_q <= 1'b0;
            end
        end
    end

    always_comb begin
        exceptionPending = (state_q != StIdle) || any_exc || any_irq;
        trapTaken        = (state_q == StTake);
        trapVector       = '0;
        if (state_q != StIdle) trapVector = isrBaseAddress + ({27'd0, cause_q} << StrideShift);
    end

    assign cause     = cause_q;
    assign epc       = epc_q;
    assign inHandler = in_handler_q;

endmodule

// File: tb/tb_exception_controller.sv
// Bench for exception_controller: directed vector table, hand sequences for IRQ/reset
// corner cases, then randomized traffic checked against a behavioural model.
module tb_exception_controller;

    localparam int unsigned NUM_IRQ       = 8;
    localparam int unsigned SYNC_STAGES   = 2;
    localparam int unsigned VECTOR_STRIDE = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [15:0]        exceptionReq = '0;
    logic [NUM_IRQ-1:0] irq = '0;
    logic [15:0]        exceptionMask = '0;
    logic               interruptEnable = 1'b0;
    logic [31:0]        isrBaseAddress = 32'h4;
    logic [31:0]        pc = '0;
    logic               trapAck = 1'b0;
    logic               eret = 1'b0;
    logic               exceptionPending;
    logic [4:0]         cause;
    logic               trapTaken;
    logic [31:0]        trapVector;
    logic [31:0]        epc;
    logic               inHandler;

    exception_controller #(
        .NUM_IRQ      (NUM_IRQ),
        .SYNC_STAGES  (SYNC_STAGES),
        .VECTOR_STRIDE(VECTOR_STRIDE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .exceptionReq    (exceptionReq),
        .irq             (irq),
        .exceptionMask   (exceptionMask),
        .interruptEnable (interruptEnable),
        .isrBaseAddress  (isrBaseAddress),
        .pc              (pc),
        .trapAck         (trapAck),
        .eret            (eret),
        .exceptionPending(exceptionPending),
        .cause           (cause),
        .trapTaken       (trapTaken),
        .trapVector      (trapVector),
        .epc             (epc),
        .inHandler       (inHandler)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] req;
        logic [15:0] mask;
        logic        ack;
        logic        ret;
        logic [31:0] pc;
        logic        pend;
        logic [4:0]  cause;
        logic        taken;
        logic        inh;
        logic [31:0] epc;
        logic        chk_vec;
        logic [31:0] vec;
    } vec_t;

    vec_t tbl[22];

    // Behavioural model state: phase 0 = no trap in flight, 1 = waiting for ack, 2 = entering.
    logic [15:0]        m_latch;
    logic [4:0]         m_cause;
    logic [31:0]        m_epc;
    logic               m_inh;
    int                 m_phase;
    logic [NUM_IRQ-1:0] m_sync[$];

    task automatic model_reset();
        m_latch = '0;
        m_cause = '0;
        m_epc   = '0;
        m_inh   = 1'b0;
        m_phase = 0;
        m_sync  = {};
        for (int i = 0; i < int'(SYNC_STAGES); i++) m_sync.push_back('0);
    endtask

    function automatic logic [4:0] pick(input logic [15:0] e, input logic [NUM_IRQ-1:0] q);
        for (int i = 0; i < 16; i++) if (e[i]) return 5'(i);
        for (int i = 0; i < int'(NUM_IRQ); i++) if (q[i]) return 5'(16 + i);
        return 5'd0;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        exceptionReq = '0; irq = '0; exceptionMask = '0; interruptEnable = 1'b0;
        trapAck = 1'b0; eret = 1'b0; pc = '0; isrBaseAddress = 32'h4;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_pend"},  32'(exceptionPending), 32'd0);
        check({tag, "_cause"}, 32'(cause), 32'd0);
        check({tag, "_epc"},   epc, 32'd0);
        check({tag, "_inh"},   32'(inHandler), 32'd0);
        check({tag, "_taken"}, 32'(trapTaken), 32'd0);
    endtask

    initial begin
        logic [15:0]        excq;
        logic [NUM_IRQ-1:0] irqq;
        logic               exp_pend;
        logic [15:0]        nl;

        tbl[0]  = '{16'h0004, 16'h0000, 1'b0, 1'b0, 32'h100, 1'b1, 5'd0, 1'b0, 1'b0, 32'h000, 1'b0, 32'h00};
        tbl[1]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 32'h104, 1'b1, 5'd2, 1'b0, 1'b0, 32'h100, 1'b1, 32'h0C};
        tbl[2]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 32'h104, 1'b1, 5'd2, 1'b0, 1'b0, 32'h100, 1'b1, 32'h0C};
        tbl[3]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 32'h104, 1'b1, 5'd2, 1'b1, 1'b0, 32'h100, 1'b1, 32'h0C};
        tbl[4]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 32'h108, 1'b0, 5'd2, 1'b0, 1'b1, 32'h100, 1'b0, 32'h00};
        tbl[5]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 32'h108, 1'b0, 5'd2, 1'b0, 1'b1, 32'h100, 1'b0, 32'h00};
        tbl[6]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 32'h10C, 1'b0, 5'd2, 1'b0, 1'b0, 32'h100, 1'b0, 32'h00};
        tbl[7]  = '{16'h0012, 16'h0000, 1'b0, 1'b0, 32'h200, 1'b1, 5'd2, 1'b0, 1'b0, 32'h100, 1'b0, 32'h00};
        tbl[8]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 32'h204, 1'b1, 5'd1, 1'b0, 1'b0, 32'h200, 1'b1, 32'h08};
        tbl[9]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 32'h204, 1'b1, 5'd1, 1'b1, 1'b0, 32'h200, 1'b1, 32'h08};
        tbl[10] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 32'h300, 1'b1, 5'd1, 1'b0, 1'b1, 32'h200, 1'b0, 32'h00};
        tbl[11] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 32'h304, 1'b1, 5'd4, 1'b0, 1'b1, 32'h300, 1'b1, 32'h14};
        tbl[12] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 32'h304, 1'b1, 5'd4, 1'b1, 1'b1, 32'h300, 1'b1, 32'h14};
        tbl[13] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 32'h308, 1'b0, 5'd4, 1'b0, 1'b1, 32'h300, 1'b0, 32'h00};
        tbl[14] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 32'h308, 1'b0, 5'd4, 1'b0, 1'b0, 32'h300, 1'b0, 32'h00};
        tbl[15] = '{16'h0008, 16'h0008, 1'b0, 1'b0, 32'h400, 1'b0, 5'd4, 1'b0, 1'b0, 32'h300, 1'b0, 32'h00};
        tbl[16] = '{16'h0000, 16'h0008, 1'b0, 1'b0, 32'h400, 1'b0, 5'd4, 1'b0, 1'b0, 32'h300, 1'b0, 32'h00};
        tbl[17] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 32'h400, 1'b1, 5'd4, 1'b0, 1'b0, 32'h300, 1'b0, 32'h00};
        tbl[18] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 32'h404, 1'b1, 5'd3, 1'b0, 1'b0, 32'h400, 1'b1, 32'h10};
        tbl[19] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 32'h404, 1'b1, 5'd3, 1'b1, 1'b0, 32'h400, 1'b1, 32'h10};
        tbl[20] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 32'h408, 1'b0, 5'd3, 1'b0, 1'b1, 32'h400, 1'b0, 32'h00};
        tbl[21] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 32'h408, 1'b0, 5'd3, 1'b0, 1'b0, 32'h400, 1'b0, 32'h00};

        do_reset();
        #1 check_idle_zero("reset");

        // Directed vectors: single exception, two-bit request, masked-then-unmasked.
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            exceptionReq = tbl[i].req; exceptionMask = tbl[i].mask;
            trapAck = tbl[i].ack; eret = tbl[i].ret; pc = tbl[i].pc;
            #1;
            check($sformatf("v%0d_pend", i),  32'(exceptionPending), 32'(tbl[i].pend));
            check($sformatf("v%0d_cause", i), 32'(cause), 32'(tbl[i].cause));
            check($sformatf("v%0d_taken", i), 32'(trapTaken), 32'(tbl[i].taken));
            check($sformatf("v%0d_inh", i),   32'(inHandler), 32'(tbl[i].inh));
            check($sformatf("v%0d_epc", i),   epc, tbl[i].epc);
            if (tbl[i].chk_vec) check($sformatf("v%0d_vec", i), trapVector, tbl[i].vec);
        end
        @(negedge clk);
        exceptionReq = '0; exceptionMask = '0; trapAck = 1'b0; eret = 1'b0;

        // IRQ latency through the synchroniser, then gating by inHandler and interruptEnable.
        interruptEnable = 1'b1; pc = 32'h500;
        @(negedge clk) irq = 8'h20;
        repeat (SYNC_STAGES - 1) @(negedge clk);
        #1 check("irq_early_pend", 32'(exceptionPending), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        check("irq_pend", 32'(exceptionPending), 32'd1);
        check("irq_cause", 32'(cause), 32'd21);
        check("irq_epc", epc, 32'h500);
        trapAck = 1'b1;
        @(negedge clk) trapAck = 1'b0;
        #1 check("irq_taken", 32'(trapTaken), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 check($sformatf("irq_inh_gate%0d", i), 32'(exceptionPending), 32'd0);
        end
        interruptEnable = 1'b0; eret = 1'b1;
        @(negedge clk) eret = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 check($sformatf("irq_ie_gate%0d", i), 32'(exceptionPending), 32'd0);
        end
        irq = '0;
        repeat (SYNC_STAGES + 1) @(negedge clk);
        interruptEnable = 1'b1;

        // Exception beats a simultaneously qualified IRQ; dropping the IRQ does not cancel.
        @(negedge clk) irq = 8'h01;
        repeat (SYNC_STAGES) @(negedge clk);
        exceptionReq = 16'h0080; pc = 32'h600;
        #1 check("prio_pend", 32'(exceptionPending), 32'd1);
        @(negedge clk) begin exceptionReq = '0; irq = '0; end
        #1 check("prio_cause", 32'(cause), 32'd7);
        trapAck = 1'b1;
        @(negedge clk) trapAck = 1'b0;
        #1;
        check("prio_taken", 32'(trapTaken), 32'd1);
        check("prio_cause2", 32'(cause), 32'd7);
        check("prio_epc", epc, 32'h600);
        @(negedge clk);
        #1 check("prio_inh", 32'(inHandler), 32'd1);

        // Vector wrap, trap inside a handler, then reset mid-PEND discards latched state.
        isrBaseAddress = 32'hFFFF_FFF0; exceptionReq = 16'h0220; exceptionMask = 16'h0200;
        pc = 32'h700;
        @(negedge clk) exceptionReq = '0;
        #1;
        check("wrap_cause", 32'(cause), 32'd5);
        check("wrap_vec", trapVector, 32'h0000_0004);
        check("wrap_epc", epc, 32'h700);
        #2 reset = 1'b1;
        #1 check_idle_zero("async_rst");
        @(negedge clk) begin reset = 1'b0; exceptionMask = '0; end
        #1 check("rst_discard", 32'(exceptionPending), 32'd0);

        // Randomized traffic against the behavioural model.
        do_reset();
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            exceptionReq = '0;
            if ($urandom_range(0, 5) == 0) exceptionReq = 16'h1 << $urandom_range(0, 15);
            if ($urandom_range(0, 15) == 0) exceptionReq = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 19) == 0) exceptionMask = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 29) == 0) interruptEnable = ~interruptEnable;
            if ($urandom_range(0, 12) == 0) irq = NUM_IRQ'($urandom) & NUM_IRQ'($urandom);
            if ($urandom_range(0, 49) == 0) isrBaseAddress = $urandom;
            trapAck = ($urandom_range(0, 2) == 0);
            eret = ($urandom_range(0, 7) == 0);
            pc = $urandom;
            #1;
            excq = (exceptionReq | m_latch) & ~exceptionMask;
            irqq = m_sync[SYNC_STAGES-1] & {NUM_IRQ{interruptEnable & ~m_inh}};
            exp_pend = (m_phase != 0) || (excq != 0) || (irqq != 0);
            check($sformatf("r%0d_pend", n),  32'(exceptionPending), 32'(exp_pend));
            check($sformatf("r%0d_cause", n), 32'(cause), 32'(m_cause));
            check($sformatf("r%0d_epc", n),   epc, m_epc);
            check($sformatf("r%0d_inh", n),   32'(inHandler), 32'(m_inh));
            check($sformatf("r%0d_taken", n), 32'(trapTaken), 32'(m_phase == 2));
            if (m_phase != 0)
                check($sformatf("r%0d_vec", n), trapVector,
                      isrBaseAddress + 32'(m_cause) * VECTOR_STRIDE);
            // Advance the model to the state after the coming clock edge.
            nl = m_latch | exceptionReq;
            if (m_phase == 2) begin
                if (m_cause < 16 && !exceptionReq[m_cause[3:0]]) nl[m_cause[3:0]] = 1'b0;
                m_inh = 1'b1;
                m_phase = 0;
            end else begin
                if (eret) m_inh = 1'b0;
                if (m_phase == 1) begin
                    if (trapAck) m_phase = 2;
                end else if (excq != 0 || irqq != 0) begin
                    m_cause = pick(excq, irqq);
                    m_epc = pc;
                    m_phase = 1;
                end
            end
            m_latch = nl;
            m_sync.push_front(irq);
            void'(m_sync.pop_back());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
